// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : Bank of NCH independent programmable clock dividers, each
//                producing a registered square wave and a one-cycle tick.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_bank #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 27,
    parameter int DEF_DIV = 4,
    parameter int CH_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 sync,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_W-1:0]     cfg_div,
    output logic [NCH-1:0]       sq_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH*CNT_W-1:0] div_rd
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_def = CNT_W'(DEF_DIV);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] r_pending;
        logic             r_sq;
        logic             r_tick;
        logic             w_wr;
        logic             w_stop;
        logic             w_last;

        // Out-of-range cfg_ch never matches any channel index, so it is dropped.
        assign w_wr   = cfg_we && (cfg_ch == CH_W'(g));
        assign w_stop = !ch_en[g] || (r_active == '0);
        assign w_last = (r_cnt == (r_active - c_one));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt     <= '0;
                r_sq      <= 1'b0;
                r_tick    <= 1'b0;
                r_active  <= c_def;
                r_pending <= c_def;
            end else begin
                if (w_wr) begin
                    r_pending <= cfg_div;
                end
                if (w_stop || sync) begin
                    r_cnt    <= '0;
                    r_sq     <= 1'b0;
                    r_tick   <= 1'b0;
                    r_active <= r_pending;
                end else if (w_last) begin
                    // Divisor reload only at a half-period boundary avoids runt pulses.
                    r_cnt    <= '0;
                    r_sq     <= ~r_sq;
                    r_tick   <= ~r_sq;
                    r_active <= r_pending;
                end else begin
                    r_cnt  <= r_cnt + c_one;
                    r_tick <= 1'b0;
                end
            end
        end

        assign sq_out[g]                = r_sq;
        assign tick[g]                  = r_tick;
        assign div_rd[g*CNT_W +: CNT_W] = r_active;
    end

endmodule
`default_nettype wire
